uart_transmitter: RTL

UART serial transmitter, the counterpart to the existing receiver on the GPIO/UART APB subsystem.
- Runs on the same 16x-oversampled baud clock as the receiver; each serial bit is held for OVERSAMPLE clk cycles.
- Accepts bytes from the APB register side through a one-entry holding register, so back-to-back frames need no idle gap.
- Serialises each frame as: start bit (0), LSB-first data, optional parity bit, then 1 or 2 stop bits (1).

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_transmitter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: state encodings,
// idle line level, default oversampling ratio and the parity helper.
package uart_pkg;

    localparam int   OVERSAMPLE_DEFAULT = 16;
    localparam logic LINE_IDLE          = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // XOR of the low nbits of data. Setting odd inverts the result, so that
    // data plus parity carries an odd number of ones.
    function automatic logic calc_parity(input logic [7:0] data,
                                         input int         nbits,
                                         input logic       odd);
        logic p;
        p = odd;
        for (int i = 0; i < 8; i++) begin
            if (i < nbits) p = p ^ data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART serial transmitter. It has a one-entry holding register in front of the
// frame serialiser, so a byte queued during a frame starts right after the
// last stop bit. Every serial bit is held for OVERSAMPLE clk cycles.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 enable,
    input  logic                 TX_start,
    input  logic [DATA_BITS-1:0] in,
    output logic                 out,
    output logic                 TX_ready,
    output logic                 TX_busy,
    output logic                 TX_done,
    output logic                 error
);

    localparam int               CNT_W     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic             PAR_ODD   = (PARITY_ODD != 0);

    // Control state (reset)
    uart_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic             r_stop_idx;
    logic             r_hold_valid;
    logic             r_out;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    // Data path (not reset; only meaningful when the control qualifies it)
    logic [7:0]       r_hold;
    logic [7:0]       r_shift;
    logic             r_par;

    // Next-state values
    uart_state_t      w_state;
    logic [CNT_W-1:0] w_cnt;
    logic [2:0]       w_bit_idx;
    logic             w_stop_idx;
    logic             w_hold_valid;
    logic             w_out;
    logic             w_ready;
    logic             w_busy;
    logic             w_done;
    logic             w_error;
    logic [7:0]       w_hold;
    logic [7:0]       w_shift;
    logic             w_par;
    logic             w_load;
    logic             w_cnt_last;

    // Next-state logic for the holding register, bit timer and frame FSM.
    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_bit_idx    = r_bit_idx;
        w_stop_idx   = r_stop_idx;
        w_hold_valid = r_hold_valid;
        w_out        = r_out;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_error      = 1'b0;
        w_hold       = r_hold;
        w_shift      = r_shift;
        w_par        = r_par;
        w_load       = 1'b0;
        w_cnt_last   = (r_cnt == CNT_LAST);

        if (!enable) begin
            // Disabled: abort any frame and flush the holding register.
            w_state      = IDLE;
            w_cnt        = '0;
            w_bit_idx    = '0;
            w_stop_idx   = 1'b0;
            w_hold_valid = 1'b0;
            w_out        = LINE_IDLE;
            w_busy       = 1'b0;
        end else begin
            // A write while the holding register is full is dropped and flagged.
            if (TX_start) begin
                if (r_ready) begin
                    w_hold       = 8'(in);
                    w_hold_valid = 1'b1;
                end else begin
                    w_error = 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    w_out  = LINE_IDLE;
                    w_busy = 1'b0;
                    if (r_hold_valid) w_load = 1'b1;
                end
                START: begin
                    if (w_cnt_last) begin
                        w_cnt     = '0;
                        w_state   = DATA;
                        w_bit_idx = '0;
                        w_out     = r_shift[0];
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_cnt_last) begin
                        w_cnt = '0;
                        if (r_bit_idx == BIT_LAST) begin
                            if (PARITY_EN != 0) begin
                                w_state = PARITY;
                                w_out   = r_par;
                            end else begin
                                w_state    = STOP;
                                w_stop_idx = 1'b0;
                                w_out      = LINE_IDLE;
                            end
                        end else begin
                            w_bit_idx = r_bit_idx + 3'd1;
                            w_out     = r_shift[r_bit_idx + 3'd1];
                        end
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (w_cnt_last) begin
                        w_cnt      = '0;
                        w_state    = STOP;
                        w_stop_idx = 1'b0;
                        w_out      = LINE_IDLE;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_cnt_last) begin
                        w_cnt = '0;
                        if (r_stop_idx == STOP_LAST) begin
                            w_done = 1'b1;
                            if (r_hold_valid) begin
                                // Queued byte: go straight into the next start bit.
                                w_load = 1'b1;
                            end else begin
                                w_state = IDLE;
                                w_busy  = 1'b0;
                                w_out   = LINE_IDLE;
                            end
                        end else begin
                            w_stop_idx = 1'b1;
                        end
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state = IDLE;
                    w_cnt   = '0;
                    w_out   = LINE_IDLE;
                    w_busy  = 1'b0;
                end
            endcase

            // Move the held byte into the shifter and begin a frame. This
            // cannot coincide with a capture, because a capture requires an
            // empty holding register.
            if (w_load) begin
                w_shift      = r_hold;
                w_par        = calc_parity(r_hold, DATA_BITS, PAR_ODD);
                w_hold_valid = 1'b0;
                w_state      = START;
                w_cnt        = '0;
                w_bit_idx    = '0;
                w_stop_idx   = 1'b0;
                w_out        = 1'b0;
                w_busy       = 1'b1;
            end
        end

        w_ready = !w_hold_valid;
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_hold_valid <= 1'b0;
            r_out        <= LINE_IDLE;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_bit_idx    <= w_bit_idx;
            r_stop_idx   <= w_stop_idx;
            r_hold_valid <= w_hold_valid;
            r_out        <= w_out;
            r_ready      <= w_ready;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_error      <= w_error;
        end
    end

    // Data registers: holding byte, frame shifter and its precomputed parity.
    always_ff @(posedge clk) begin
        r_hold  <= w_hold;
        r_shift <= w_shift;
        r_par   <= w_par;
    end

    assign out      = r_out;
    assign TX_ready = r_ready;
    assign TX_busy  = r_busy;
    assign TX_done  = r_done;
    assign error    = r_error;

endmodule
